// File: rtl/isa_shared_pkg.sv
// Shared ISA-level types and constants used by the front-end pipeline.
package isa_shared_pkg;

  // Bytes per instruction word; the fetch PC advances by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Fetch stage state: normal fetching, or halted on a misaligned redirect target.
  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, used as the in-order prefetch queue.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   flush           empty the FIFO at this edge (dominates push/pop)
//   push, wdata     write an entry
//   pop             drop the head entry (ignored when empty)
//   rdata           head entry, combinational
//   count           number of valid entries
//   empty, full     occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  // Pointer and occupancy next-state; flush overrides everything.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    push_en = push;
    pop_en  = pop && !empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_en) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop_en) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to instruction
// memory, buffers returned words in an in-order prefetch queue and presents
// {instr, instr_pc} to decode over valid/ready. Redirects flush the queue and
// discard every read still in flight.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   imem_req/addr/gnt          request channel (addr word aligned, held until gnt)
//   imem_rvalid/rdata          in-order response channel
//   instr_valid/ready          queue head handshake; instr, instr_pc = head payload
//   redirect, redirect_pc      new fetch target (takes effect at this edge)
//   fetch_fault                last redirect target was misaligned; fetch halted
module fetch_unit
  import isa_shared_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0,
  parameter int unsigned             QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [CW-1:0]           q_count;
  logic                    q_empty, q_full;
  logic                    q_push, q_pop;
  logic [2*DATA_WIDTH-1:0] q_rdata;
  logic                    credit_ok, grant;
  logic [DATA_WIDTH-1:0]   target_pc;

  // Request and queue control. Credit counts both queued and in-flight words,
  // so a response always has a free slot waiting for it.
  always_comb begin
    target_pc   = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    credit_ok   = (SW'(q_count) + SW'(outst_q)) < SW'(QDEPTH);
    imem_req    = rst_n && (state_q == FETCH_RUN) && !redirect && credit_ok;
    imem_addr   = fetch_pc_q;
    grant       = imem_req && imem_gnt;
    instr_valid = !q_empty;
    q_pop       = instr_valid && instr_ready;
    q_push      = imem_rvalid && (discard_q == '0) && !redirect;
    fetch_fault = (state_q == FETCH_FAULT);
  end

  assign {instr, instr_pc} = q_rdata;

  // Next-state for the FSM, PCs and read accounting.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      outst_d    = outst_d + CW'(1);
    end
    if (imem_rvalid) begin
      outst_d = outst_d - CW'(1);
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
    end
    if (q_push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end

    // No grant happens in a redirect cycle, so every read still in flight after
    // this edge belongs to the old path and must be dropped.
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      discard_d  = outst_d;
      state_d    = (redirect_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (q_push),
    .pop   (q_pop),
    .wdata ({imem_rdata, resp_pc_q}),
    .rdata (q_rdata),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Credit accounting must make a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized-timing run, with a
// scoreboard of expected {instr, pc} per fetch path and an independent monitor.
module tb_fetch_unit;

  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_gnt  = 0;
  int n_deliv = 0;
  logic [31:0] last_pc = '0;
  int gnt_mode = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .QDEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Instruction memory: in-order responses after a per-request latency.
  initial begin
    pend_t       pend[$];
    logic        waiting;
    logic [31:0] wait_addr;
    waiting     = 1'b0;
    wait_addr   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = DEAD;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pend.delete();
        waiting = 1'b0;
      end else begin
        if (waiting && !redirect) begin
          check("req_held", 32'(imem_req), 32'd1);
          check("addr_held", imem_addr, wait_addr);
        end
        if (imem_req) begin
          check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        end
        if (imem_req && imem_gnt) begin
          pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
          n_gnt++;
        end
        waiting   = imem_req && !imem_gnt;
        wait_addr = imem_addr;
        if (imem_rvalid && pend.size() > 0) begin
          void'(pend.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = DEAD;
      end
      imem_gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    end
  end

  // Monitor: compare each handshake against the expected stream of the current path.
  initial begin
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] base;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty: got pc 0x%08h, expected no delivery", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.data);
        end
        n_deliv++;
        last_pc = instr_pc;
      end
      @(posedge clk);
      if (rst_n !== 1'b1 || redirect === 1'b1) begin
        base = (rst_n !== 1'b1) ? 32'h0 : {redirect_pc[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
          exp_q.push_back('{pc: base + 32'(4 * i), data: mem_word(base + 32'(4 * i))});
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int k;
    int d0;
    int g0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // 1: streaming from reset, first valid two cycles after the first request
    instr_ready = 1'b1;
    rst_n = 1'b1;
    d0 = n_deliv;
    #1;
    k = 0;
    while (!imem_req && k < 10) begin step(); k++; end
    check("t1_first_addr", imem_addr, 32'h0);
    k = 0;
    while (!instr_valid && k < 10) begin step(); k++; end
    check("t1_valid_latency", 32'(k), 32'd2);
    repeat (20) step();
    check("t1_deliveries", 32'((n_deliv - d0) >= 15), 32'd1);

    // 2: consumer stalled, exactly QDEPTH grants then one more after one pop
    instr_ready = 1'b0;
    do_reset();
    g0 = n_gnt;
    repeat (10) step();
    check("t2_grants", 32'(n_gnt - g0), 32'd4);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_req_after_pop", 32'(imem_req), 32'd1);
    check("t2_addr_after_pop", imem_addr, 32'h10);
    repeat (5) step();
    check("t2_grants_after_pop", 32'(n_gnt - g0), 32'd5);
    check("t2_req_off_again", 32'(imem_req), 32'd0);

    // 3: redirect with reads in flight
    lat_min = 2;
    lat_max = 2;
    instr_ready = 1'b1;
    do_reset();
    repeat (6) step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("t3_no_req_in_redirect", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check("t3_req_after", 32'(imem_req), 32'd1);
    check("t3_addr_after", imem_addr, 32'h100);
    d0 = n_deliv;
    k = 0;
    while (n_deliv == d0 && k < 20) begin step(); k++; end
    check("t3_first_pc", last_pc, 32'h100);
    lat_min = 1;
    lat_max = 1;
    repeat (10) step();

    // 4: redirect coinciding with a response, then a second redirect back-to-back
    k = 0;
    while (!imem_rvalid && k < 20) begin step(); k++; end
    check("t4_rvalid_seen", 32'(imem_rvalid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h180;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    d0 = n_deliv;
    k = 0;
    while (n_deliv == d0 && k < 20) begin step(); k++; end
    check("t4_first_pc", last_pc, 32'h200);
    repeat (20) step();
    check("t4_deliveries", 32'((n_deliv - d0) >= 10), 32'd1);
    check("t4_last_pc_path", 32'(last_pc >= 32'h200 && last_pc < 32'h300), 32'd1);

    // 5: misaligned target faults, aligned target recovers
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    d0 = n_deliv;
    for (int i = 0; i < 3; i++) begin
      check("t5_fault", 32'(fetch_fault), 32'd1);
      check("t5_req", 32'(imem_req), 32'd0);
      check("t5_valid", 32'(instr_valid), 32'd0);
      step();
    end
    check("t5_no_delivery", 32'(n_deliv - d0), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("t5_fault_clear", 32'(fetch_fault), 32'd0);
    k = 0;
    while (n_deliv == d0 && k < 20) begin step(); k++; end
    check("t5_first_pc", last_pc, 32'h40);

    // 6: random grant, latency, ready and redirects
    gnt_mode = 1;
    lat_min = 1;
    lat_max = 4;
    d0 = n_deliv;
    for (int i = 0; i < 800; i++) begin
      instr_ready = 1'($urandom_range(1, 0));
      if ($urandom_range(59, 0) == 0) begin
        redirect = 1'b1;
        redirect_pc = 32'($urandom_range(1023, 0)) << 2;
      end else begin
        redirect = 1'b0;
      end
      step();
    end
    redirect = 1'b0;
    instr_ready = 1'b1;
    repeat (30) step();
    check("t6_deliveries", 32'((n_deliv - d0) > 100), 32'd1);

    // reset in the middle of traffic: old responses never reach the consumer
    rst_n = 1'b0;
    repeat (2) step();
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;
    rst_n = 1'b1;
    d0 = n_deliv;
    k = 0;
    while (n_deliv == d0 && k < 20) begin step(); k++; end
    check("t7_first_pc_after_reset", last_pc, 32'h0);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
